// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the restoring divider.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Width of an iteration counter that must hold the values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_ripple_subtractor.sv
// Combinational A - B built as a full-adder chain on inverted B with carry-in 1.
module ripple_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_inv;

  assign carry[0] = 1'b1;
  assign b_inv    = ~b;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign diff[gi]      = a[gi] ^ b_inv[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b_inv[gi]) | (carry[gi] & (a[gi] ^ b_inv[gi]));
    end
  endgenerate

  // No carry out of the chain means A < B.
  assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock, start/done handshake.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, r_reg, d_reg;
  logic [CW-1:0]    count_reg;
  logic             div_zero_reg;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             trial_borrow;
  logic             fits;

  assign accept    = start_i && (state_reg != RUN);
  assign last_iter = (count_reg == CW'(WIDTH - 1));

  // Partial remainder after shifting the next dividend bit in from Q.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};

  ripple_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a      (r_shift),
    .b      ({1'b0, d_reg}),
    .diff   (trial),
    .borrow (trial_borrow)
  );

  // Without a borrow the top bit is always clear since D < 2^WIDTH.
  assign fits = !trial_borrow && !trial[WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          state_next = (divisor_i == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_reg == RUN);
    done_o = (state_reg == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_reg        <= '0;
      r_reg        <= '0;
      d_reg        <= '0;
      count_reg    <= '0;
      div_zero_reg <= 1'b0;
    end else if (accept) begin
      count_reg <= '0;
      if (divisor_i == '0) begin
        q_reg        <= '1;
        r_reg        <= dividend_i;
        div_zero_reg <= 1'b1;
      end else begin
        d_reg        <= divisor_i;
        q_reg        <= dividend_i;
        r_reg        <= '0;
        div_zero_reg <= 1'b0;
      end
    end else if (state_reg == RUN) begin
      count_reg <= count_reg + 1'b1;
      q_reg     <= {q_reg[WIDTH-2:0], fits};
      r_reg     <= fits ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    end
  end

  assign quotient_o  = q_reg;
  assign remainder_o = r_reg;
  assign div_zero_o  = div_zero_reg;

endmodule
